// File: rtl/alu_arbiter.sv
// Two-requester arbiter that shares one 8-bit ALU over valid/ready handshakes.
// Define ALU_ARB_FIXED_PRIORITY_EN for fixed priority (req0 wins); default is round-robin.
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [7:0] REQ0_OP1,
  input  logic [7:0] REQ0_OP2,
  input  logic [2:0] REQ0_SELECT,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [7:0] REQ1_OP1,
  input  logic [7:0] REQ1_OP2,
  input  logic [2:0] REQ1_SELECT,
  output logic       RSP0_VALID,
  input  logic       RSP0_READY,
  output logic       RSP1_VALID,
  input  logic       RSP1_READY,
  output logic [7:0] RSP_RESULT,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state, state_next;
  logic       owner;
  logic [3:0] counter;
  logic       grant1;
  logic       accept;
  logic       rsp_done;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  assign grant1 = REQ1_VALID && !REQ0_VALID;
`else
  logic last_served;
  // On a tie, serve whoever was not served last.
  assign grant1 = REQ1_VALID && (!REQ0_VALID || !last_served);
`endif

  always_comb begin
    state_next = state;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    RSP0_VALID = 1'b0;
    RSP1_VALID = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        REQ0_READY = !RESET && REQ0_VALID && !grant1;
        REQ1_READY = !RESET && grant1;
        accept     = REQ0_READY || REQ1_READY;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        if (counter == 4'd1) state_next = RESP;
      end
      RESP: begin
        RSP0_VALID = !owner;
        RSP1_VALID = owner;
        rsp_done   = owner ? RSP1_READY : RSP0_READY;
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      owner      <= 1'b0;
      counter    <= '0;
      ALU_DATA1  <= '0;
      ALU_DATA2  <= '0;
      ALU_SELECT <= '0;
      RSP_RESULT <= '0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      last_served <= 1'b1;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant1;
            counter    <= 4'(SETTLE_CYCLES);
            ALU_DATA1  <= grant1 ? REQ1_OP1 : REQ0_OP1;
            ALU_DATA2  <= grant1 ? REQ1_OP2 : REQ0_OP2;
            ALU_SELECT <= grant1 ? REQ1_SELECT : REQ0_SELECT;
          end
        end
        BUSY: begin
          if (counter == 4'd1) RSP_RESULT <= ALU_RESULT;
          counter <= counter - 4'd1;
        end
        RESP: begin
`ifndef ALU_ARB_FIXED_PRIORITY_EN
          if (rsp_done) last_served <= owner;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  logic       CLK;
  logic       RESET;
  logic       REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [7:0] REQ0_OP1, REQ0_OP2, REQ1_OP1, REQ1_OP2;
  logic [2:0] REQ0_SELECT, REQ1_SELECT;
  logic       RSP0_VALID, RSP0_READY, RSP1_VALID, RSP1_READY;
  logic [7:0] RSP_RESULT, ALU_DATA1, ALU_DATA2, ALU_RESULT;
  logic [2:0] ALU_SELECT;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_OP1(REQ0_OP1), .REQ0_OP2(REQ0_OP2), .REQ0_SELECT(REQ0_SELECT),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_OP1(REQ1_OP1), .REQ1_OP2(REQ1_OP2), .REQ1_SELECT(REQ1_SELECT),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY),
    .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
    .RSP_RESULT(RSP_RESULT),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT)
  );

  // Shared ALU: 000 forward DATA2, 001 add, 010 and, 011 or, others 0.
  always_comb begin
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA2;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = 8'h00;
    endcase
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // One contended round: both requesters valid, expected winner g.
  task automatic rr_round(input logic g);
    #1;
    check("rr_ready0", REQ0_READY, {7'd0, !g});
    check("rr_ready1", REQ1_READY, {7'd0, g});
    step();
    check("rr_select", ALU_SELECT, g ? 8'd3 : 8'd2);
    step();
    check("rr_rsp_early", RSP0_VALID | RSP1_VALID, 8'd0);
    step();
    check("rr_rsp0", RSP0_VALID, {7'd0, !g});
    check("rr_rsp1", RSP1_VALID, {7'd0, g});
    check("rr_result", RSP_RESULT, g ? 8'hAA : 8'h00);
    if (g) RSP1_READY = 1'b1; else RSP0_READY = 1'b1;
    step();
    RSP0_READY = 1'b0;
    RSP1_READY = 1'b0;
  endtask

  initial begin
    logic g;
    RESET = 1'b1;
    REQ0_VALID = 1'b1; REQ0_OP1 = 8'h05; REQ0_OP2 = 8'h04; REQ0_SELECT = 3'b001;
    REQ1_VALID = 1'b1; REQ1_OP1 = 8'hA0; REQ1_OP2 = 8'h0A; REQ1_SELECT = 3'b011;
    RSP0_READY = 1'b0; RSP1_READY = 1'b0;

    // Reset with both requesters valid
    step(); step();
    check("rst_ready0", REQ0_READY, 8'd0);
    check("rst_ready1", REQ1_READY, 8'd0);
    check("rst_data1", ALU_DATA1, 8'd0);
    check("rst_data2", ALU_DATA2, 8'd0);
    check("rst_select", ALU_SELECT, 8'd0);
    check("rst_result", RSP_RESULT, 8'd0);
    check("rst_rsp", {6'd0, RSP1_VALID, RSP0_VALID}, 8'd0);
    RESET = 1'b0;
    #1;
    check("first_ready0", REQ0_READY, 8'd1);
    check("first_ready1", REQ1_READY, 8'd0);

    // Single add 5+4 on req0
    step();
    REQ0_VALID = 1'b0;
    check("add_busy_ready", REQ0_READY | REQ1_READY, 8'd0);
    check("add_data1", ALU_DATA1, 8'h05);
    check("add_data2", ALU_DATA2, 8'h04);
    check("add_select", ALU_SELECT, 8'd1);
    check("add_rsp_t0", RSP0_VALID, 8'd0);
    step();
    check("add_rsp_t1", RSP0_VALID, 8'd0);
    step();
    check("add_rsp0", RSP0_VALID, 8'd1);
    check("add_rsp1", RSP1_VALID, 8'd0);
    check("add_result", RSP_RESULT, 8'h09);
    RSP0_READY = 1'b1;
    step();
    RSP0_READY = 1'b0;
    #1;
    check("add_done_rsp0", RSP0_VALID, 8'd0);
    check("waiting_req1_ready", REQ1_READY, 8'd1);

    // Contention: req0 and F0&0A, req1 or A0|0A
    REQ0_VALID = 1'b1; REQ0_OP1 = 8'hF0; REQ0_OP2 = 8'h0A; REQ0_SELECT = 3'b010;
    for (int r = 0; r < 4; r++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      g = 1'b0;
`else
      g = (r % 2 == 0);
`endif
      rr_round(g);
    end

    // Backpressure on req1 response; req0 must wait
    REQ0_VALID = 1'b0;
    REQ1_OP1 = 8'h10; REQ1_OP2 = 8'h20; REQ1_SELECT = 3'b001;
    #1;
    check("bp_ready1", REQ1_READY, 8'd1);
    step();
    REQ1_VALID = 1'b0;
    REQ0_VALID = 1'b1; REQ0_OP1 = 8'h77; REQ0_OP2 = 8'h0A; REQ0_SELECT = 3'b000;
    step(); step();
    check("bp_rsp1", RSP1_VALID, 8'd1);
    check("bp_result", RSP_RESULT, 8'h30);
    RSP0_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_rsp1", RSP1_VALID, 8'd1);
      check("bp_hold_rsp0", RSP0_VALID, 8'd0);
      check("bp_hold_result", RSP_RESULT, 8'h30);
      check("bp_hold_ready0", REQ0_READY, 8'd0);
    end
    RSP0_READY = 1'b0;
    RSP1_READY = 1'b1;
    step();
    RSP1_READY = 1'b0;
    check("bp_after_rsp1", RSP1_VALID, 8'd0);
    check("bp_after_ready0", REQ0_READY, 8'd1);

    // Forward opcode on req0
    step();
    REQ0_VALID = 1'b0;
    check("fwd_select", ALU_SELECT, 8'd0);
    check("fwd_data2", ALU_DATA2, 8'h0A);
    step();
    check("fwd_rsp_t1", RSP0_VALID, 8'd0);
    step();
    check("fwd_rsp0", RSP0_VALID, 8'd1);
    check("fwd_result", RSP_RESULT, 8'h0A);
    RSP0_READY = 1'b1;
    step();
    RSP0_READY = 1'b0;

    // Invalid opcode 101 yields 0
    REQ0_VALID = 1'b1; REQ0_OP1 = 8'hFF; REQ0_OP2 = 8'hFF; REQ0_SELECT = 3'b101;
    #1;
    check("inv_ready0", REQ0_READY, 8'd1);
    step();
    REQ0_VALID = 1'b0;
    check("inv_select", ALU_SELECT, 8'd5);
    step();
    check("inv_rsp_t1", RSP0_VALID, 8'd0);
    step();
    check("inv_rsp0", RSP0_VALID, 8'd1);
    check("inv_result", RSP_RESULT, 8'h00);
    RSP0_READY = 1'b1;
    step();
    RSP0_READY = 1'b0;

    // Reset while BUSY abandons the operation
    REQ0_VALID = 1'b1; REQ0_OP1 = 8'h03; REQ0_OP2 = 8'h04; REQ0_SELECT = 3'b001;
    step();
    REQ0_VALID = 1'b0;
    check("mid_select_pre", ALU_SELECT, 8'd1);
    step();
    RESET = 1'b1;
    step();
    check("mid_select", ALU_SELECT, 8'd0);
    check("mid_data1", ALU_DATA1, 8'd0);
    check("mid_data2", ALU_DATA2, 8'd0);
    check("mid_result", RSP_RESULT, 8'd0);
    check("mid_rsp0", RSP0_VALID, 8'd0);
    RESET = 1'b0;
    RSP0_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_no_rsp", {6'd0, RSP1_VALID, RSP0_VALID}, 8'd0);
    end
    RSP0_READY = 1'b0;

    // last-served back to 1 after reset: req0 wins the tie
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    #1;
    check("post_rst_ready0", REQ0_READY, 8'd1);
    check("post_rst_ready1", REQ1_READY, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
